scandoubler_2x: RTL and testbench

- Downstream of the 5 MHz sync/counter stage. Converts the 15 kHz arcade raster (one pixel per ce_5M, 326 pixels/line) into a 31 kHz raster at clk_10M.
- Each input line is captured into one bank of a ping-pong line buffer while the other bank is replayed twice at double rate.
- Regenerates hsync; vsync and blank are carried through with the line delay.
- Feeds the HDMI/VGA encoder.

---
 rtl/scandoubler_pkg.sv | 16 +
 rtl/scandoubler_line_buffer.sv | 25 ++
 rtl/scandoubler_2x.sv | 189 ++++++++++++++++++
 tb/tb_scandoubler_2x.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scandoubler_pkg.sv
// Shared constants and the pixel word layout for the 2x scandoubler.
package scandoubler_pkg;

    localparam int ADDR_W       = 9;
    localparam int LINE_MAX     = 512;
    localparam int HS_WIDTH_DEF = 38;
    localparam int CH_W_DEF     = 4;

    typedef struct packed {
        logic                blank;
        logic [CH_W_DEF-1:0] r;
        logic [CH_W_DEF-1:0] g;
        logic [CH_W_DEF-1:0] b;
    } pix_t;

endpackage

// File: rtl/scandoubler_line_buffer.sv
// Simple dual-port line RAM: one write port, one registered read port (read-before-write).
module line_buffer_dp
    import scandoubler_pkg::*;
#(
    parameter int DATA_W    = 13,
    parameter int ADDR_BITS = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/scandoubler_2x.sv
// 15 kHz -> 31 kHz line doubler: one ping-pong bank captures while the other replays twice.
// Optional SCANDOUBLER_SCANLINES_EN halves every channel on the second replay pass.
module scandoubler_2x
    import scandoubler_pkg::*;
#(
    parameter int CH_W     = 4,
    parameter int HS_WIDTH = HS_WIDTH_DEF,
    parameter int LINE_MAX = scandoubler_pkg::LINE_MAX
) (
    input  logic            clk_10M,
    input  logic            reset_n,
    input  logic            ce_5M,
    input  logic [CH_W-1:0] in_r,
    input  logic [CH_W-1:0] in_g,
    input  logic [CH_W-1:0] in_b,
    input  logic            in_hsync,
    input  logic            in_vsync,
    input  logic            in_hblank,
    input  logic            in_vblank,
    output logic [CH_W-1:0] out_r,
    output logic [CH_W-1:0] out_g,
    output logic [CH_W-1:0] out_b,
    output logic            out_hsync,
    output logic            out_vsync,
    output logic            out_blank,
    output logic            out_valid
);

    localparam int              PIX_W     = 3*CH_W + 1;
    localparam int              AW        = $clog2(LINE_MAX);
    localparam logic [AW-1:0]   WADDR_MAX = AW'(LINE_MAX - 1);
    localparam logic [AW-1:0]   HS_END    = AW'(HS_WIDTH);

    logic            r_hs_d;
    logic [AW-1:0]   r_waddr;
    logic [AW-1:0]   r_line_len;
    logic [AW-1:0]   r_raddr;
    logic            r_wbank;
    logic            r_pass;
    logic            r_vs_line;
    logic            r_seen;
    logic            r_valid;

    logic            w_boundary;
    logic            w_we;
    logic            w_wbank_sel;
    logic [AW-1:0]   w_waddr_eff;
    logic [AW:0]     w_waddr;
    logic [AW:0]     w_raddr;
    logic [PIX_W-1:0] w_pix;
    logic [PIX_W-1:0] w_rdata_p1;

    assign w_boundary  = ce_5M & in_hsync & ~r_hs_d;
    assign w_we        = ce_5M & (w_boundary | (r_waddr != WADDR_MAX));
    assign w_wbank_sel = w_boundary ? ~r_wbank : r_wbank;
    assign w_waddr_eff = w_boundary ? '0 : r_waddr;
    assign w_waddr     = {w_wbank_sel, w_waddr_eff};
    assign w_raddr     = {~r_wbank, r_raddr};
    assign w_pix       = {in_hblank | in_vblank, in_r, in_g, in_b};
    assign out_valid   = r_valid;

    // Input side: capture on ce_5M, swap banks on each hsync rising edge
    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d     <= 1'b0;
            r_waddr    <= '0;
            r_line_len <= '0;
            r_wbank    <= 1'b0;
            r_vs_line  <= 1'b0;
            r_seen     <= 1'b0;
            r_valid    <= 1'b0;
        end else if (ce_5M) begin
            r_hs_d <= in_hsync;
            if (w_boundary) begin
                r_line_len <= r_waddr;
                r_wbank    <= ~r_wbank;
                r_waddr    <= AW'(1);
                r_vs_line  <= in_vsync;
                r_seen     <= 1'b1;
                if (r_seen) begin
                    r_valid <= 1'b1;
                end
            end else if (r_waddr != WADDR_MAX) begin
                r_waddr <= r_waddr + AW'(1);
            end
        end
    end

    // Replay side: a boundary restarts the read so a short last pass is cut, never stretched
    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr <= '0;
            r_pass  <= 1'b0;
        end else if (w_boundary) begin
            r_raddr <= '0;
            r_pass  <= 1'b0;
        end else if (r_line_len == '0) begin
            r_raddr <= '0;
        end else if (r_raddr >= r_line_len - AW'(1)) begin
            r_raddr <= '0;
            r_pass  <= ~r_pass;
        end else begin
            r_raddr <= r_raddr + AW'(1);
        end
    end

    line_buffer_dp #(
        .DATA_W    (PIX_W),
        .ADDR_BITS (AW + 1)
    ) u_buf (
        .clk     (clk_10M),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_pix),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata_p1)
    );

    // Stage p1: control travelling alongside the RAM read
    logic r_hs_p1;
    logic r_vs_p1;
    logic r_valid_p1;
    logic r_empty_p1;

    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_p1    <= 1'b0;
            r_vs_p1    <= 1'b0;
            r_valid_p1 <= 1'b0;
            r_empty_p1 <= 1'b1;
        end else begin
            r_hs_p1    <= (r_raddr < HS_END);
            r_vs_p1    <= r_vs_line;
            r_valid_p1 <= r_valid;
            r_empty_p1 <= (r_line_len == '0);
        end
    end

    logic            w_blank_p1;
    logic [CH_W-1:0] w_r_p1;
    logic [CH_W-1:0] w_g_p1;
    logic [CH_W-1:0] w_b_p1;

    assign w_blank_p1 = w_rdata_p1[PIX_W-1] | ~r_valid_p1 | r_empty_p1;

`ifdef SCANDOUBLER_SCANLINES_EN
    function automatic logic [CH_W-1:0] dim_ch(input logic [CH_W-1:0] v, input logic dim);
        return dim ? (v >> 1) : v;
    endfunction

    logic r_pass_p1;

    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            r_pass_p1 <= 1'b0;
        end else begin
            r_pass_p1 <= r_pass;
        end
    end

    assign w_r_p1 = dim_ch(w_rdata_p1[3*CH_W-1:2*CH_W], r_pass_p1);
    assign w_g_p1 = dim_ch(w_rdata_p1[2*CH_W-1:CH_W],   r_pass_p1);
    assign w_b_p1 = dim_ch(w_rdata_p1[CH_W-1:0],        r_pass_p1);
`else
    assign w_r_p1 = w_rdata_p1[3*CH_W-1:2*CH_W];
    assign w_g_p1 = w_rdata_p1[2*CH_W-1:CH_W];
    assign w_b_p1 = w_rdata_p1[CH_W-1:0];
`endif

    // Stage p2: output registers, colour forced to black while blanked
    always_ff @(posedge clk_10M or negedge reset_n) begin
        if (!reset_n) begin
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_blank <= 1'b1;
        end else begin
            out_r     <= w_blank_p1 ? '0 : w_r_p1;
            out_g     <= w_blank_p1 ? '0 : w_g_p1;
            out_b     <= w_blank_p1 ? '0 : w_b_p1;
            out_hsync <= r_hs_p1;
            out_vsync <= r_vs_p1;
            out_blank <= w_blank_p1;
        end
    end

endmodule

// File: tb/tb_scandoubler_2x.sv
// Scoreboard bench for scandoubler_2x: a line-level model predicts every output cycle.
`timescale 1ns/1ps
module tb_scandoubler_2x;

    localparam int HSW  = 38;
    localparam int LMAX = 512;

    logic       clk_10M = 1'b0;
    logic       reset_n;
    logic       ce_5M;
    logic [3:0] in_r, in_g, in_b;
    logic       in_hsync, in_vsync, in_hblank, in_vblank;
    logic [3:0] out_r, out_g, out_b;
    logic       out_hsync, out_vsync, out_blank, out_valid;

    scandoubler_2x dut (
        .clk_10M   (clk_10M),
        .reset_n   (reset_n),
        .ce_5M     (ce_5M),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_hblank (in_hblank),
        .in_vblank (in_vblank),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync),
        .out_blank (out_blank),
        .out_valid (out_valid)
    );

    always #50 clk_10M = ~clk_10M;

    int errors = 0;
    int checks = 0;

    // Replay descriptor: what the output shows two clocks after this state
    typedef struct packed {
        logic        mark;
        logic [12:0] word;
        int          k;
        logic        pass;
        int          len;
        logic        valid;
        logic        vs;
    } desc_t;

    int          e_cnt = 0;
    int          m_eb  = 0;
    int          m_nb  = 0;
    int          m_len = 0;
    logic        m_hs_d = 1'b0;
    logic        m_vs   = 1'b0;
    logic [12:0] m_cur[$];
    logic [12:0] m_prev[$];
    desc_t       d1, d2;
    logic [15:0] exp_q[$];

    function automatic desc_t desc_mark();
        desc_t d;
        d = '0;
        d.mark = 1'b1;
        return d;
    endfunction

    function automatic desc_t desc_now();
        desc_t d;
        d = '0;
        d.len   = m_len;
        d.valid = (m_nb >= 2);
        d.vs    = m_vs;
        if (m_len != 0) begin
            d.k    = (e_cnt - m_eb) % m_len;
            d.pass = (((e_cnt - m_eb) / m_len) % 2) == 1;
        end
        d.word = (m_prev.size() > d.k) ? m_prev[d.k] : 13'h0;
        return d;
    endfunction

    function automatic logic [15:0] render(input desc_t d, input logic vnow);
        logic       hs, bl;
        logic [3:0] r, g, b;
        if (d.mark) return {vnow, 3'b001, 12'h000};
        hs = (d.k < HSW);
        bl = d.word[12] | ~d.valid | (d.len == 0);
        r  = d.word[11:8];
        g  = d.word[7:4];
        b  = d.word[3:0];
`ifdef SCANDOUBLER_SCANLINES_EN
        if (d.pass) begin
            r = r >> 1;
            g = g >> 1;
            b = b >> 1;
        end
`endif
        if (bl) begin
            r = 4'h0;
            g = 4'h0;
            b = 4'h0;
        end
        return {vnow, hs, d.vs, bl, r, g, b};
    endfunction

    task automatic model_edge();
        logic [12:0] w;
        desc_t       dn;
        e_cnt++;
        if (!reset_n) begin
            m_hs_d = 1'b0;
            m_cur.delete();
            m_len = 0;
            m_nb  = 0;
            m_vs  = 1'b0;
            m_eb  = e_cnt;
            exp_q.push_back(render(desc_mark(), 1'b0));
            d2 = desc_mark();
            d1 = desc_now();
            return;
        end
        if (ce_5M) begin
            w = {in_hblank | in_vblank, in_r, in_g, in_b};
            if (in_hsync && !m_hs_d) begin
                m_prev = m_cur;
                m_len  = m_cur.size();
                m_cur.delete();
                m_cur.push_back(w);
                m_eb = e_cnt;
                m_vs = in_vsync;
                m_nb++;
            end else if (m_cur.size() < LMAX - 1) begin
                m_cur.push_back(w);
            end
            m_hs_d = in_hsync;
        end
        dn = desc_now();
        exp_q.push_back(render(d2, m_nb >= 2));
        d2 = d1;
        d1 = dn;
    endtask

    logic [15:0] mon_ex, mon_ac;
    always @(negedge clk_10M) begin
        if (exp_q.size() > 0) begin
            mon_ex = exp_q.pop_front();
            mon_ac = {out_valid, out_hsync, out_vsync, out_blank, out_r, out_g, out_b};
            checks++;
            if (mon_ac !== mon_ex) begin
                errors++;
                $display("FAIL stream t=%0t actual={v,hs,vs,bl,rgb}=%h required=%h", $time, mon_ac, mon_ex);
            end
        end
    end

    task automatic check_reset_now(input string tag);
        logic [15:0] ac;
        ac = {out_valid, out_hsync, out_vsync, out_blank, out_r, out_g, out_b};
        checks++;
        if (ac !== 16'h1000) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", tag, ac, 16'h1000);
        end
    endtask

    task automatic tick(input logic ce, input logic hs, input logic vs,
                        input logic hb, input logic vb, input logic [11:0] rgb);
        ce_5M     = ce;
        in_hsync  = hs;
        in_vsync  = vs;
        in_hblank = hb;
        in_vblank = vb;
        {in_r, in_g, in_b} = rgb;
        @(posedge clk_10M);
        model_edge();
        #10;
    endtask

    task automatic pixel(input logic hs, input logic vs, input logic hb,
                         input logic vb, input logic [11:0] rgb);
        tick(1'b1, hs, vs, hb, vb, rgb);
        tick(1'b0, hs, vs, hb, vb, rgb);
    endtask

    // mode 0: x mod 16 on all channels, 1: random colour, 2: constant 14
    task automatic send_line(input int n, input int x0, input int x1, input int hs_len,
                             input logic vs, input logic vb, input int mode);
        logic [3:0]  v;
        logic [11:0] rgb;
        for (int x = x0; x < x1; x++) begin
            v = 4'(x % 16);
            case (mode)
                0:       rgb = {v, v, v};
                1:       rgb = 12'($urandom);
                default: rgb = 12'hEEE;
            endcase
            pixel(x < hs_len, vs, (x >= n - 12), vb, rgb);
        end
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        d1 = desc_mark();
        d2 = desc_mark();
        ce_5M = 1'b0; in_hsync = 1'b0; in_vsync = 1'b1; in_hblank = 1'b0; in_vblank = 1'b0;
        in_r = 4'h0; in_g = 4'h0; in_b = 4'h0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #9 check_reset_now("reset_at_start");
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
        #50 reset_n = 1'b1;

        for (int l = 0; l < 4; l++) send_line(326, 0, 326, 4, 1'b1, 1'b0, 0);
        send_line(200, 0, 200, 4, 1'b1, 1'b0, 0);
        send_line(326, 0, 326, 4, 1'b1, 1'b0, 0);

        for (int l = 0; l < 5; l++) begin
            n = $urandom_range(300, 340);
            send_line(n, 0, n, 4, (l >= 3), (l < 2), 1);
        end

        send_line(326, 0, 100, 4, 1'b1, 1'b0, 0);
        #50 reset_n = 1'b0;
        #10 check_reset_now("reset_mid_line");
        send_line(326, 100, 103, 4, 1'b1, 1'b0, 0);
        #50 reset_n = 1'b1;
        send_line(326, 103, 326, 4, 1'b1, 1'b0, 0);
        for (int l = 0; l < 3; l++) send_line(326, 0, 326, 4, 1'b1, 1'b0, 0);

        send_line(600, 0, 600, 4, 1'b1, 1'b0, 1);
        for (int l = 0; l < 2; l++) send_line(326, 0, 326, 4, 1'b1, 1'b0, 0);

        for (int l = 0; l < 3; l++) send_line(326, 0, 326, 4, 1'b1, 1'b0, 2);

        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(100, 450);
            send_line(n, 0, n, $urandom_range(1, 8), 1'($urandom), 1'b0, 1);
        end

        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0);
        @(negedge clk_10M);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
